// File: rtl/phase_accumulator.sv
// phase_accumulator: DDS phase accumulator whose per-tick increment glides toward a loaded target.
// The increment moves by at most GLIDE_STEP per TICK and never overshoots or wraps.
module phase_accumulator #(
    parameter logic [31:0] PHASE_INIT = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TICK,
    input  logic        RUN,
    input  logic [31:0] FREQ_IN,
    input  logic        FREQ_LOAD,
    input  logic [31:0] GLIDE_STEP,
    input  logic        PHASE_SYNC,
    output logic [31:0] DDS,
    output logic        WRAP,
    output logic [31:0] FREQ_CUR,
    output logic        GLIDING
);
    logic [31:0] dds_q, dds_d, cur_q, cur_d, tgt_q, tgt_d, glide_d, diff;
    logic        wrap_q, wrap_d, gliding_q, gliding_d, up, acc;
    logic [32:0] sum;

    always_comb begin
        sum = {1'b0, dds_q} + {1'b0, cur_q};
        up = cur_q < tgt_q;
        diff = up ? tgt_q - cur_q : cur_q - tgt_q;
        // A zero step means "no glide": jump straight to the target.
        glide_d = (GLIDE_STEP == '0 || diff <= GLIDE_STEP) ? tgt_q :
                  up ? cur_q + GLIDE_STEP : cur_q - GLIDE_STEP;
        acc = TICK && RUN && !PHASE_SYNC;
        dds_d = PHASE_SYNC ? PHASE_INIT : acc ? sum[31:0] : dds_q;
        wrap_d = acc && sum[32];
        tgt_d = FREQ_LOAD ? FREQ_IN : tgt_q;
        cur_d = (FREQ_LOAD && GLIDE_STEP == '0) ? FREQ_IN : TICK ? glide_d : cur_q;
        gliding_d = cur_d != tgt_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dds_q     <= PHASE_INIT;
            wrap_q    <= 1'b0;
            cur_q     <= '0;
            tgt_q     <= '0;
            gliding_q <= 1'b0;
        end else begin
            dds_q     <= dds_d;
            wrap_q    <= wrap_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            gliding_q <= gliding_d;
        end
    end

    assign DDS      = dds_q;
    assign WRAP     = wrap_q;
    assign FREQ_CUR = cur_q;
    assign GLIDING  = gliding_q;
endmodule

// File: tb/tb_phase_accumulator.sv
// tb_phase_accumulator: directed scenarios with hand-computed expectations for phase_accumulator.
module tb_phase_accumulator;
    localparam logic [31:0] INIT = 32'h0000_1000;

    logic        CLK = 1'b0;
    logic        RESET, TICK, RUN, FREQ_LOAD, PHASE_SYNC;
    logic [31:0] FREQ_IN, GLIDE_STEP;
    logic [31:0] DDS, FREQ_CUR;
    logic        WRAP, GLIDING;
    int          total = 0;
    int          bad = 0;

    phase_accumulator #(.PHASE_INIT(INIT)) dut (
        .CLK(CLK), .RESET(RESET), .TICK(TICK), .RUN(RUN), .FREQ_IN(FREQ_IN),
        .FREQ_LOAD(FREQ_LOAD), .GLIDE_STEP(GLIDE_STEP), .PHASE_SYNC(PHASE_SYNC),
        .DDS(DDS), .WRAP(WRAP), .FREQ_CUR(FREQ_CUR), .GLIDING(GLIDING)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RESET = 0; TICK = 0; RUN = 0; FREQ_LOAD = 0; PHASE_SYNC = 0;
        FREQ_IN = '0; GLIDE_STEP = '0;
    endtask

    task automatic do_reset();
        idle();
        RESET = 1;
        cyc();
        RESET = 0;
    endtask

    task automatic test_reset();
        idle();
        RESET = 1; TICK = 1; RUN = 1; FREQ_LOAD = 1; FREQ_IN = 32'h123; PHASE_SYNC = 1;
        cyc();
        total++; if (DDS !== INIT) begin bad++; $display("FAIL reset_dds got %h want %h", DDS, INIT); end
        total++; if (WRAP !== 1'b0) begin bad++; $display("FAIL reset_wrap got %b want 0", WRAP); end
        total++; if (FREQ_CUR !== 32'h0) begin bad++; $display("FAIL reset_cur got %h want 0", FREQ_CUR); end
        total++; if (GLIDING !== 1'b0) begin bad++; $display("FAIL reset_gliding got %b want 0", GLIDING); end
        idle(); TICK = 1; RUN = 1;
        cyc();
        total++; if (DDS !== INIT) begin bad++; $display("FAIL reset_idle_dds got %h want %h", DDS, INIT); end
    endtask

    task automatic test_step_load();
        logic [31:0] exp;
        do_reset();
        GLIDE_STEP = 0; FREQ_IN = 32'h2000_0000; FREQ_LOAD = 1; RUN = 1;
        cyc();
        total++; if (FREQ_CUR !== 32'h2000_0000) begin bad++; $display("FAIL load_cur got %h want 20000000", FREQ_CUR); end
        total++; if (GLIDING !== 1'b0) begin bad++; $display("FAIL load_gliding got %b want 0", GLIDING); end
        total++; if (DDS !== INIT) begin bad++; $display("FAIL load_dds got %h want %h", DDS, INIT); end
        FREQ_LOAD = 0; TICK = 1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            exp = INIT + 32'h2000_0000 * i;
            total++; if (DDS !== exp) begin bad++; $display("FAIL ramp_dds[%0d] got %h want %h", i, DDS, exp); end
            total++; if (WRAP !== (i == 8)) begin bad++; $display("FAIL ramp_wrap[%0d] got %b want %b", i, WRAP, i == 8); end
        end
        TICK = 0;
        cyc();
        total++; if (WRAP !== 1'b0) begin bad++; $display("FAIL wrap_pulse got %b want 0", WRAP); end
        total++; if (DDS !== INIT) begin bad++; $display("FAIL hold_dds got %h want %h", DDS, INIT); end
    endtask

    task automatic test_glide_up();
        logic [31:0] cur_e[4] = '{32'h100, 32'h200, 32'h300, 32'h350};
        logic [31:0] dds_e[4] = '{32'h1000, 32'h1100, 32'h1300, 32'h1600};
        do_reset();
        GLIDE_STEP = 32'h100; FREQ_IN = 32'h350; FREQ_LOAD = 1;
        cyc();
        total++; if (FREQ_CUR !== 32'h0) begin bad++; $display("FAIL up_load_cur got %h want 0", FREQ_CUR); end
        total++; if (GLIDING !== 1'b1) begin bad++; $display("FAIL up_load_gliding got %b want 1", GLIDING); end
        FREQ_LOAD = 0; TICK = 1; RUN = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++; if (FREQ_CUR !== cur_e[i]) begin bad++; $display("FAIL up_cur[%0d] got %h want %h", i, FREQ_CUR, cur_e[i]); end
            total++; if (GLIDING !== (i != 3)) begin bad++; $display("FAIL up_gliding[%0d] got %b want %b", i, GLIDING, i != 3); end
            total++; if (DDS !== dds_e[i]) begin bad++; $display("FAIL up_dds[%0d] got %h want %h", i, DDS, dds_e[i]); end
        end
    endtask

    task automatic test_glide_down();
        do_reset();
        FREQ_IN = 32'h350; FREQ_LOAD = 1;
        cyc();
        GLIDE_STEP = 32'h200; FREQ_IN = 32'h0;
        cyc();
        total++; if (FREQ_CUR !== 32'h350 || GLIDING !== 1'b1) begin bad++; $display("FAIL down_start got %h/%b want 350/1", FREQ_CUR, GLIDING); end
        FREQ_LOAD = 0; TICK = 1; RUN = 1;
        cyc();
        total++; if (FREQ_CUR !== 32'h150 || GLIDING !== 1'b1) begin bad++; $display("FAIL down_1 got %h/%b want 150/1", FREQ_CUR, GLIDING); end
        total++; if (DDS !== 32'h1350) begin bad++; $display("FAIL down_dds_1 got %h want 1350", DDS); end
        cyc();
        total++; if (FREQ_CUR !== 32'h0 || GLIDING !== 1'b0) begin bad++; $display("FAIL down_2 got %h/%b want 0/0", FREQ_CUR, GLIDING); end
        total++; if (DDS !== 32'h14a0) begin bad++; $display("FAIL down_dds_2 got %h want 14a0", DDS); end
        cyc();
        total++; if (FREQ_CUR !== 32'h0) begin bad++; $display("FAIL down_settled got %h want 0", FREQ_CUR); end
    endtask

    task automatic test_run_freeze();
        do_reset();
        GLIDE_STEP = 32'h100; FREQ_IN = 32'h300; FREQ_LOAD = 1;
        cyc();
        FREQ_LOAD = 0; TICK = 1; RUN = 0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            total++; if (FREQ_CUR !== 32'h100 * i) begin bad++; $display("FAIL freeze_cur[%0d] got %h want %h", i, FREQ_CUR, 32'h100 * i); end
            total++; if (DDS !== INIT || WRAP !== 1'b0) begin bad++; $display("FAIL freeze_dds[%0d] got %h/%b want %h/0", i, DDS, WRAP, INIT); end
        end
    endtask

    task automatic test_load_with_tick();
        do_reset();
        FREQ_IN = 32'h300; FREQ_LOAD = 1;
        cyc();
        GLIDE_STEP = 32'h100; FREQ_IN = 32'h50; TICK = 1; RUN = 1;
        cyc();
        total++; if (FREQ_CUR !== 32'h300 || GLIDING !== 1'b1) begin bad++; $display("FAIL same_cycle_cur got %h/%b want 300/1", FREQ_CUR, GLIDING); end
        total++; if (DDS !== 32'h1300) begin bad++; $display("FAIL same_cycle_dds got %h want 1300", DDS); end
        FREQ_LOAD = 0;
        cyc();
        total++; if (FREQ_CUR !== 32'h200) begin bad++; $display("FAIL after_load_cur got %h want 200", FREQ_CUR); end
        total++; if (DDS !== 32'h1600) begin bad++; $display("FAIL after_load_dds got %h want 1600", DDS); end
        GLIDE_STEP = 0;
        cyc();
        total++; if (FREQ_CUR !== 32'h50 || GLIDING !== 1'b0) begin bad++; $display("FAIL step0_jump got %h/%b want 50/0", FREQ_CUR, GLIDING); end
        total++; if (DDS !== 32'h1800) begin bad++; $display("FAIL step0_dds got %h want 1800", DDS); end
    endtask

    task automatic test_reset_mid_glide();
        do_reset();
        GLIDE_STEP = 32'h100; FREQ_IN = 32'h5000; FREQ_LOAD = 1;
        cyc();
        FREQ_LOAD = 0; TICK = 1; RUN = 1;
        cyc(); cyc();
        total++; if (FREQ_CUR !== 32'h200) begin bad++; $display("FAIL mid_glide_cur got %h want 200", FREQ_CUR); end
        RESET = 1;
        cyc();
        total++; if (DDS !== INIT || WRAP !== 1'b0 || FREQ_CUR !== 32'h0 || GLIDING !== 1'b0)
            begin bad++; $display("FAIL mid_reset got %h/%b/%h/%b want %h/0/0/0", DDS, WRAP, FREQ_CUR, GLIDING, INIT); end
        RESET = 0;
        cyc(); cyc(); cyc();
        total++; if (FREQ_CUR !== 32'h0 || GLIDING !== 1'b0 || DDS !== INIT)
            begin bad++; $display("FAIL post_reset_idle got %h/%b/%h want 0/0/%h", FREQ_CUR, GLIDING, DDS, INIT); end
    endtask

    task automatic test_sync_and_wrap();
        do_reset();
        FREQ_IN = 32'hFFFF_EFF0; FREQ_LOAD = 1;
        cyc();
        FREQ_LOAD = 0; TICK = 1; RUN = 1;
        cyc();
        total++; if (DDS !== 32'hFFFF_FFF0 || WRAP !== 1'b0) begin bad++; $display("FAIL near_top got %h/%b want fffffff0/0", DDS, WRAP); end
        TICK = 0; FREQ_IN = 32'h20; FREQ_LOAD = 1;
        cyc();
        FREQ_LOAD = 0; TICK = 1; PHASE_SYNC = 1;
        cyc();
        total++; if (DDS !== INIT || WRAP !== 1'b0) begin bad++; $display("FAIL sync_tick got %h/%b want %h/0", DDS, WRAP, INIT); end
        PHASE_SYNC = 0; FREQ_IN = 32'hFFFF_EFF0; FREQ_LOAD = 1; TICK = 0;
        cyc();
        FREQ_LOAD = 0; TICK = 1;
        cyc();
        TICK = 0; FREQ_IN = 32'h10; FREQ_LOAD = 1;
        cyc();
        FREQ_LOAD = 0; TICK = 1;
        cyc();
        total++; if (DDS !== 32'h0 || WRAP !== 1'b1) begin bad++; $display("FAIL exact_wrap got %h/%b want 0/1", DDS, WRAP); end
        cyc();
        total++; if (DDS !== 32'h10 || WRAP !== 1'b0) begin bad++; $display("FAIL after_wrap got %h/%b want 10/0", DDS, WRAP); end
    endtask

    initial begin
        idle();
        cyc();
        test_reset();
        test_step_load();
        test_glide_up();
        test_glide_down();
        test_run_freeze();
        test_load_with_tick();
        test_reset_mid_glide();
        test_sync_and_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/phase_accumulator.md
PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

Interface
REQ-001 The module SHALL have parameter PHASE_INIT, default 32'h00000000, giving the phase value loaded on reset and on hard sync.
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port TICK, input, 1 bit: sample-rate strobe; one accumulation step per cycle in which TICK=1.
REQ-005 The module SHALL have port RUN, input, 1 bit: 1 enables phase accumulation, 0 freezes phase.
REQ-006 The module SHALL have port FREQ_IN, input, 32 bits: new target frequency word (phase increment per TICK).
REQ-007 The module SHALL have port FREQ_LOAD, input, 1 bit: single-cycle strobe that captures FREQ_IN as the target.
REQ-008 The module SHALL have port GLIDE_STEP, input, 32 bits, unsigned: maximum change of the current increment per TICK; 0 means no glide.
REQ-009 The module SHALL have port PHASE_SYNC, input, 1 bit: hard sync, forces phase to PHASE_INIT.
REQ-010 The module SHALL have port DDS, output reg, 32 bits: current phase word, consumed by the sine table (top 3 bits select the table entry).
REQ-011 The module SHALL have port WRAP, output reg, 1 bit: one-cycle pulse when the phase overflows 2^32.
REQ-012 The module SHALL have port FREQ_CUR, output reg, 32 bits: increment currently applied.
REQ-013 The module SHALL have port GLIDING, output reg, 1 bit: 1 while FREQ_CUR differs from the target.

Function
REQ-014 When TICK=1 and RUN=1 and PHASE_SYNC=0, DDS SHALL become (DDS + FREQ_CUR) mod 2^32 on the next edge, using the FREQ_CUR value held before this edge.
REQ-015 WRAP SHALL be 1 in exactly the cycle after an accumulation whose 33-bit sum carries out, and 0 in every other cycle.
REQ-016 When TICK=0 or RUN=0, DDS SHALL hold its value and WRAP SHALL be 0.
REQ-017 PHASE_SYNC=1 SHALL load DDS with PHASE_INIT on the next edge, overriding any accumulation in that cycle, with WRAP=0.
REQ-018 FREQ_LOAD=1 SHALL write FREQ_IN to the internal target register on the next edge; the new target SHALL take effect from the following TICK.
REQ-019 FREQ_LOAD=1 with GLIDE_STEP=0 SHALL also write FREQ_IN to FREQ_CUR on the next edge; this overrides any glide update in that cycle.
REQ-020 On each TICK (independent of RUN), glide SHALL update FREQ_CUR as follows.
- If FREQ_CUR < target and (target - FREQ_CUR) <= GLIDE_STEP: FREQ_CUR <= target.
- Else if FREQ_CUR < target: FREQ_CUR <= FREQ_CUR + GLIDE_STEP.
- The same rule SHALL apply downward when FREQ_CUR > target.
- All comparisons and differences SHALL be 32-bit unsigned; the result SHALL never overshoot the target and never wrap.
REQ-021 If GLIDE_STEP=0 and FREQ_CUR != target (step changed after a load), FREQ_CUR SHALL jump to the target on the next TICK.
REQ-022 FREQ_LOAD and TICK in the same cycle: the glide step SHALL use the old target, and accumulation SHALL use the old FREQ_CUR.
REQ-023 GLIDING SHALL be a registered output equal to (FREQ_CUR != target) after each edge, so it reflects the post-edge values.
REQ-024 Latency SHALL be one cycle from TICK, PHASE_SYNC or FREQ_LOAD to the corresponding output change.

Reset
REQ-025 RESET=1 at a clock edge SHALL set DDS=PHASE_INIT, WRAP=0, FREQ_CUR=0, target=0 and GLIDING=0, overriding all other inputs including a TICK in the same cycle.
REQ-026 Reset applied during an active glide SHALL abort the glide; after release the block SHALL idle until the next FREQ_LOAD.

Verification
REQ-027 Load at GLIDE_STEP=0, FREQ_IN=32'h20000000, RUN=1, TICK every cycle -> DDS=0,2000_0000,4000_0000,...,E000_0000, then 0 with WRAP=1 for one cycle (8 ticks per period).
REQ-028 GLIDE_STEP=32'h100, target change from 0 to 32'h350 -> FREQ_CUR=100,200,300,350 on successive TICKs; GLIDING falls with the 350 update.
REQ-029 Downward glide from 32'h350 to 32'h0 with step 32'h200 -> FREQ_CUR=150, then 0; no underflow.
REQ-030 PHASE_SYNC and TICK asserted together at DDS=32'hFFFFFFF0, FREQ_CUR=32'h20 -> DDS=PHASE_INIT, WRAP=0.
REQ-031 RUN=0 with TICKs during a glide -> DDS frozen while FREQ_CUR still ramps to the target.
REQ-032 RESET asserted mid-glide together with TICK -> all outputs 0 (DDS=PHASE_INIT) on the next cycle; no WRAP.
